cnt_rollover_logger: RTL and testbench

Downstream consumer of the up/down counter (`counter_ud`): watches its `rollover` output and logs each wrap event as a timestamped record.
- Records are held in a small FIFO and drained by software-facing logic over a valid/ready handshake.
- A sticky overflow flag and a saturating drop counter report events lost when the FIFO is full.

---
 rtl/cnt_log_pkg.sv | 21 ++
 rtl/cnt_log_fifo.sv | 66 ++++++
 rtl/cnt_rollover_logger.sv | 93 +++++++++
 tb/tb_cnt_rollover_logger.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_log_pkg.sv
// Shared types and constants for the counter rollover logger.
// The record layout below matches the logger's default WIDTH/TS_W parameters.
package cnt_log_pkg;

    localparam int LOG_WIDTH = 4;
    localparam int LOG_TS_W  = 16;

    typedef struct packed {
        logic                 down;
        logic [LOG_WIDTH-1:0] count;
        logic [LOG_TS_W-1:0]  stamp;
    } cnt_log_rec_t;

    localparam logic [7:0] DROP_MAX = 8'd255;

    // Saturating increment for the dropped-event counter.
    function automatic logic [7:0] drop_inc(input logic [7:0] cnt);
        return (cnt == DROP_MAX) ? DROP_MAX : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/cnt_log_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy level.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module cnt_log_fifo #(
    parameter int DW    = 21,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [DW-1:0] last_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign level   = level_q;

    // When empty the output keeps showing the last record that was popped,
    // so a slot overwritten later never leaks onto the output.
    assign pop_data = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            last_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cnt_rollover_logger.sv
// Logs rising edges of a counter's rollover output as timestamped records
// in a FIFO, with a sticky overflow flag and saturating drop counter.
module cnt_rollover_logger
    import cnt_log_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [WIDTH-1:0]         count,
    input  logic                     down,
    input  logic                     load_en,
    input  logic                     rollover,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_down,
    output logic [WIDTH-1:0]         out_count,
    output logic [TS_W-1:0]          out_stamp,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    input  logic                     clr_overflow
);

    localparam int REC_W = 1 + WIDTH + TS_W;

    logic [TS_W-1:0]  ts_q;
    logic             rollover_q;
    logic             ev_det;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] push_rec;
    logic [REC_W-1:0] head_rec;

    // Handshake: a record transfers on any posedge where out_valid and
    // out_ready are both high; out_* stay stable while out_valid=1 and
    // out_ready=0, and out_valid never depends on out_ready.
    assign pop       = out_valid & out_ready;
    assign out_valid = ~fifo_empty;

    // Rising edge only, and never while the counter is being loaded.
    assign ev_det   = rollover & ~rollover_q & ~load_en;
    assign drop     = ev_det & fifo_full & ~pop;
    assign push_rec = {down, count, ts_q};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_q       <= '0;
            rollover_q <= 1'b0;
        end else begin
            ts_q       <= ts_q + TS_W'(1);
            rollover_q <= rollover;
        end
    end

    // A drop in the same cycle as a clear wins and restarts the count at 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= clr_overflow ? 8'd1 : drop_inc(drop_cnt);
        end else if (clr_overflow) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end
    end

    cnt_log_fifo #(
        .DW    (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (ev_det),
        .push_data (push_rec),
        .pop       (pop),
        .pop_data  (head_rec),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign out_down  = head_rec[REC_W-1];
    assign out_count = head_rec[TS_W +: WIDTH];
    assign out_stamp = head_rec[TS_W-1:0];

endmodule

// File: tb/tb_cnt_rollover_logger.sv
// Self-checking bench for cnt_rollover_logger: hand-written vector table,
// directed corner sequences and randomized traffic against a queue model.
module tb_cnt_rollover_logger;
    import cnt_log_pkg::*;

    localparam int WIDTH = 4;
    localparam int TS_W  = 16;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int REC_W = 1 + WIDTH + TS_W;

    logic             clk;
    logic             rstn;
    logic [WIDTH-1:0] count;
    logic             down;
    logic             load_en;
    logic             rollover;
    logic             out_valid;
    logic             out_ready;
    logic             out_down;
    logic [WIDTH-1:0] out_count;
    logic [TS_W-1:0]  out_stamp;
    logic [LW-1:0]    level;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic             clr_overflow;

    cnt_rollover_logger #(.WIDTH(WIDTH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .count        (count),
        .down         (down),
        .load_en      (load_en),
        .rollover     (rollover),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_down     (out_down),
        .out_count    (out_count),
        .out_stamp    (out_stamp),
        .level        (level),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .clr_overflow (clr_overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] m_last;
    int               m_ts;
    bit               m_roll_q;
    bit               m_ovf;
    int               m_drop;

    task automatic model_reset();
        exp_q.delete();
        m_last   = '0;
        m_ts     = 0;
        m_roll_q = 1'b0;
        m_ovf    = 1'b0;
        m_drop   = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit           pop;
        bit           ev;
        bit           was_full;
        bit           dropped;
        cnt_log_rec_t r;
        pop      = (exp_q.size() != 0) && out_ready;
        ev       = rollover && !m_roll_q && !load_en;
        was_full = (exp_q.size() == DEPTH);
        dropped  = 1'b0;
        r.down   = down;
        r.count  = count;
        r.stamp  = 16'(m_ts);
        if (pop) m_last = exp_q.pop_front();
        if (ev) begin
            if (!was_full || pop) exp_q.push_back(r);
            else dropped = 1'b1;
        end
        if (dropped) begin
            m_ovf  = 1'b1;
            m_drop = clr_overflow ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else if (clr_overflow) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        m_roll_q = rollover;
        m_ts     = (m_ts + 1) % 65536;
    endtask

    task automatic check_model();
        cnt_log_rec_t h;
        h = (exp_q.size() != 0) ? exp_q[0] : m_last;
        chk("m_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("m_level", 32'(level), 32'(exp_q.size()));
        chk("m_down", 32'(out_down), 32'(h.down));
        chk("m_count", 32'(out_count), 32'(h.count));
        chk("m_stamp", 32'(out_stamp), 32'(h.stamp));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input bit roll, input bit load, input bit dn,
                          input logic [WIDTH-1:0] cnt, input bit rdy, input bit clr);
        rollover     = roll;
        load_en      = load;
        down         = dn;
        count        = cnt;
        out_ready    = rdy;
        clr_overflow = clr;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic hard_reset();
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic pulse_event(input bit dn, input logic [WIDTH-1:0] cnt, input bit rdy);
        set_in(1'b1, 1'b0, dn, cnt, rdy, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, dn, cnt, rdy, 1'b0);
        cycle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit               roll;
        bit               load;
        bit               dn;
        logic [WIDTH-1:0] cnt;
        bit               rdy;
        bit               e_valid;
        int               e_level;
        int               e_stamp;
        int               e_count;
        bit               e_down;
    } vec_t;

    vec_t tv[21];

    function automatic vec_t mk(input bit roll, input bit load, input bit dn, input int cnt,
                                input bit rdy, input bit ev, input int lv, input int st,
                                input int ec, input bit ed);
        vec_t v;
        v.roll = roll; v.load = load; v.dn = dn; v.cnt = 4'(cnt); v.rdy = rdy;
        v.e_valid = ev; v.e_level = lv; v.e_stamp = st; v.e_count = ec; v.e_down = ed;
        return v;
    endfunction

    initial begin : watchdog
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: time limit reached, got %0t expected finish", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : main
        int prev_stamp;
        n_cmp  = 0;
        n_fail = 0;
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        hard_reset();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_stamp", 32'(out_stamp), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);

        // Row k is sampled at the posedge where the timestamp reads k.
        for (int i = 0; i < 10; i++) tv[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[10] = mk(1, 0, 0, 0, 0, 1, 1, 10, 0, 0);
        tv[11] = mk(0, 0, 0, 0, 0, 1, 1, 10, 0, 0);
        tv[12] = mk(0, 0, 0, 0, 1, 0, 0, 10, 0, 0);
        tv[13] = mk(1, 1, 0, 3, 0, 0, 0, 10, 0, 0);
        tv[14] = mk(0, 0, 0, 0, 0, 0, 0, 10, 0, 0);
        for (int i = 15; i < 20; i++) tv[i] = mk(1, 0, 1, 7, 0, 1, 1, 15, 7, 1);
        tv[20] = mk(0, 0, 1, 7, 1, 0, 0, 15, 7, 1);

        for (int i = 0; i < 21; i++) begin
            set_in(tv[i].roll, tv[i].load, tv[i].dn, tv[i].cnt, tv[i].rdy, 1'b0);
            cycle();
            chk("tv_valid", 32'(out_valid), 32'(tv[i].e_valid));
            chk("tv_level", 32'(level), 32'(tv[i].e_level));
            chk("tv_stamp", 32'(out_stamp), 32'(tv[i].e_stamp));
            chk("tv_count", 32'(out_count), 32'(tv[i].e_count));
            chk("tv_down", 32'(out_down), 32'(tv[i].e_down));
            chk("tv_overflow", 32'(overflow), 32'd0);
        end

        // Six events with no consumer: four stored, two dropped.
        for (int i = 0; i < 6; i++) pulse_event(i[0], 4'(i), 1'b0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        prev_stamp = -1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_count", 32'(out_count), 32'(i));
            chk("drain_stamp_incr", 32'(int'(out_stamp) > prev_stamp), 32'd1);
            prev_stamp = int'(out_stamp);
            set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            cycle();
        end
        chk("drain_level", 32'(level), 32'd0);

        // Full FIFO plus a pop in the same cycle as an event: push accepted.
        for (int i = 0; i < 4; i++) pulse_event(1'b0, 4'(i + 8), 1'b0);
        set_in(1'b1, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
        cycle();
        chk("popfull_level", 32'(level), 32'd4);
        chk("popfull_drop_cnt", 32'(drop_cnt), 32'd2);
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle();

        // Saturation, then clear racing a drop, then clear alone.
        for (int i = 0; i < 300; i++) pulse_event(1'b0, 4'(i), 1'b0);
        chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);
        chk("sat_overflow", 32'(overflow), 32'd1);
        set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        cycle();
        chk("clr_drop_overflow", 32'(overflow), 32'd1);
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        cycle();
        chk("clr_alone_overflow", 32'(overflow), 32'd0);
        chk("clr_alone_cnt", 32'(drop_cnt), 32'd0);

        // Asynchronous reset in the middle of a drain at level 3.
        pulse_event(1'b1, 4'd5, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        cycle();
        chk("midrst_pre_level", 32'(level), 32'd3);
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("midrst_stamp", 32'(out_stamp), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        set_in(1'b1, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
        cycle();
        chk("postrst_valid", 32'(out_valid), 32'd1);
        chk("postrst_stamp", 32'(out_stamp), 32'd3);
        chk("postrst_count", 32'(out_count), 32'd12);

        // Randomized traffic with alternating consumer pressure.
        for (int i = 0; i < 2500; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 200) % 2 == 0) ? 80 : 20;
            set_in($urandom_range(0, 2) == 0,
                   $urandom_range(0, 7) == 0,
                   1'($urandom),
                   4'($urandom),
                   $urandom_range(0, 99) < rdy_pct,
                   $urandom_range(0, 31) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
